// File: rtl/cam_frame_packer_if.sv
// Camera byte stream in, 17-bit pixel-queue write port out.
// The packer sits on the slave side; the camera/queue environment drives master.
interface cam_frame_packer_if;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        cam_data_valid;
    logic        queue_full;
    logic [16:0] queue_data_out;
    logic        queue_wr_en;

    modport slave (
        input  cam_vsync, cam_href, cam_data, cam_data_valid, queue_full,
        output queue_data_out, queue_wr_en
    );

    modport master (
        output cam_vsync, cam_href, cam_data, cam_data_valid, queue_full,
        input  queue_data_out, queue_wr_en
    );
endinterface

// File: rtl/cam_frame_packer.sv
// Packs an OV7670-style byte stream into RGB565 words with frame/row markers,
// cropped to the LCD geometry, for the LCD controller's pixel queue.
module cam_frame_packer #(
    parameter int unsigned FRAME_WIDTH  = 480,
    parameter int unsigned FRAME_HEIGHT = 272
) (
    input  logic                     clk,
    input  logic                     reset_n,
    cam_frame_packer_if.slave        bus,
    output logic                     frame_done,
    output logic                     overflow
);

    localparam logic [16:0] MARK_FRAME_START = 17'h10000;
    localparam logic [16:0] MARK_ROW_START   = 17'h10001;
    localparam logic [16:0] MARK_FRAME_END   = 17'h1FFFF;

    typedef enum logic [2:0] {
        IDLE, FRAME_START, WAIT_ROW, ROW_DATA, SKIP_ROW, FRAME_END, DROP
    } state_t;

    state_t      state;
    logic        vsync_q, href_q;
    logic [10:0] row_cnt, col_cnt;
    logic        phase;
    logic [7:0]  hi_byte;

    logic vsync_rise, vsync_fall, href_rise, href_fall;

    assign vsync_rise = bus.cam_vsync  & ~vsync_q;
    assign vsync_fall = ~bus.cam_vsync & vsync_q;
    assign href_rise  = bus.cam_href   & ~href_q;
    assign href_fall  = ~bus.cam_href  & href_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= IDLE;
            vsync_q            <= 1'b0;
            href_q             <= 1'b0;
            row_cnt            <= '0;
            col_cnt            <= '0;
            phase              <= 1'b0;
            hi_byte            <= '0;
            bus.queue_data_out <= '0;
            bus.queue_wr_en    <= 1'b0;
            frame_done         <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            vsync_q         <= bus.cam_vsync;
            href_q          <= bus.cam_href;
            bus.queue_wr_en <= 1'b0;
            frame_done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (vsync_fall) state <= FRAME_START;
                end

                FRAME_START: begin
                    if (!bus.queue_full) begin
                        bus.queue_data_out <= MARK_FRAME_START;
                        bus.queue_wr_en    <= 1'b1;
                        row_cnt            <= '0;
                        state              <= WAIT_ROW;
                    end
                end

                WAIT_ROW: begin
                    if (vsync_rise) begin
                        state <= FRAME_END;
                    end else if (href_rise) begin
                        if (row_cnt < 11'(FRAME_HEIGHT)) begin
                            if (bus.queue_full) begin
                                overflow <= 1'b1;
                                state    <= DROP;
                            end else begin
                                bus.queue_data_out <= MARK_ROW_START;
                                bus.queue_wr_en    <= 1'b1;
                                col_cnt            <= '0;
                                // A byte arriving with the href edge is the row's first (high) byte.
                                phase              <= bus.cam_data_valid;
                                if (bus.cam_data_valid) hi_byte <= bus.cam_data;
                                state              <= ROW_DATA;
                            end
                        end else begin
                            state <= SKIP_ROW;
                        end
                    end
                end

                ROW_DATA: begin
                    if (vsync_rise) begin
                        row_cnt <= row_cnt + 11'd1;
                        phase   <= 1'b0;
                        state   <= FRAME_END;
                    end else if (href_fall) begin
                        row_cnt <= row_cnt + 11'd1;
                        phase   <= 1'b0;
                        state   <= WAIT_ROW;
                    end else if (bus.cam_href && bus.cam_data_valid) begin
                        if (!phase) begin
                            hi_byte <= bus.cam_data;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (col_cnt < 11'(FRAME_WIDTH)) begin
                                if (bus.queue_full) begin
                                    overflow <= 1'b1;
                                    state    <= DROP;
                                end else begin
                                    bus.queue_data_out <= {1'b0, hi_byte, bus.cam_data};
                                    bus.queue_wr_en    <= 1'b1;
                                    col_cnt            <= col_cnt + 11'd1;
                                end
                            end
                        end
                    end
                end

                SKIP_ROW: begin
                    if (vsync_rise)     state <= FRAME_END;
                    else if (href_fall) state <= WAIT_ROW;
                end

                FRAME_END: begin
                    if (!bus.queue_full) begin
                        bus.queue_data_out <= MARK_FRAME_END;
                        bus.queue_wr_en    <= 1'b1;
                        frame_done         <= 1'b1;
                        state              <= IDLE;
                    end
                end

                DROP: begin
                    if (vsync_rise) state <= FRAME_END;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_packer.sv
// Bench for cam_frame_packer: a full-size and a 4x2-cropped instance share the
// camera stream; written words are checked against per-instance expected queues.
module tb_cam_frame_packer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vsync, href, valid;
    logic [7:0] data;
    logic       qf_a, qf_b;

    cam_frame_packer_if if_a ();
    cam_frame_packer_if if_b ();

    assign if_a.cam_vsync      = vsync;
    assign if_a.cam_href       = href;
    assign if_a.cam_data       = data;
    assign if_a.cam_data_valid = valid;
    assign if_a.queue_full     = qf_a;
    assign if_b.cam_vsync      = vsync;
    assign if_b.cam_href       = href;
    assign if_b.cam_data       = data;
    assign if_b.cam_data_valid = valid;
    assign if_b.queue_full     = qf_b;

    logic fd_a, fd_b, ovf_a, ovf_b;

    cam_frame_packer dut_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a), .frame_done(fd_a), .overflow(ovf_a)
    );

    cam_frame_packer #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b), .frame_done(fd_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt_a = 0;
    int fd_cnt_b = 0;
    logic [16:0] exp_a[$];
    logic [16:0] exp_b[$];
    logic [7:0]  bts[0:3][0:15];

    typedef struct {
        int   rows;
        int   nbytes;
        int   full_pix;
        logic ovf_a;
        bit   fixed;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (if_a.queue_wr_en) begin
            if (exp_a.size() == 0) check("a_unexpected_word", {15'd0, if_a.queue_data_out}, 32'hDEAD);
            else check("a_word", {15'd0, if_a.queue_data_out}, {15'd0, exp_a.pop_front()});
        end
        if (if_b.queue_wr_en) begin
            if (exp_b.size() == 0) check("b_unexpected_word", {15'd0, if_b.queue_data_out}, 32'hDEAD);
            else check("b_word", {15'd0, if_b.queue_data_out}, {15'd0, exp_b.pop_front()});
        end
        if (fd_a) begin
            fd_cnt_a++;
            check("a_done_with_end", {14'd0, if_a.queue_wr_en, if_a.queue_data_out}, {14'd0, 1'b1, 17'h1FFFF});
        end
        if (fd_b) begin
            fd_cnt_b++;
            check("b_done_with_end", {14'd0, if_b.queue_wr_en, if_b.queue_data_out}, {14'd0, 1'b1, 17'h1FFFF});
        end
    end

    function automatic logic [16:0] pix(input int r, input int p);
        return {1'b0, bts[r][2*p], bts[r][2*p+1]};
    endfunction

    task automatic fill_bytes(input bit fixed);
        logic [7:0] pat[6];
        pat = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 16; i++)
                bts[r][i] = fixed ? pat[i % 6] : 8'($urandom);
    endtask

    // Frame-level expectation: crop to W x H, stop after the overflowing pixel.
    task automatic push_frame(input int rows, input int nbytes, input int full_pix);
        exp_a.push_back(17'h10000);
        for (int r = 0; r < rows; r++) begin
            if (full_pix >= 0 && r > 0) break;
            exp_a.push_back(17'h10001);
            for (int p = 0; p < nbytes / 2; p++) begin
                if (full_pix >= 0 && p >= full_pix) break;
                exp_a.push_back(pix(r, p));
            end
        end
        exp_a.push_back(17'h1FFFF);
        exp_b.push_back(17'h10000);
        for (int r = 0; r < rows && r < 2; r++) begin
            exp_b.push_back(17'h10001);
            for (int p = 0; p < nbytes / 2 && p < 4; p++) exp_b.push_back(pix(r, p));
        end
        exp_b.push_back(17'h1FFFF);
    endtask

    task automatic send_row(input int r, input int nbytes, input int full_pix);
        href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            data  = bts[r][i];
            valid = 1'b1;
            if (r == 0 && full_pix >= 0 && i == 2 * full_pix + 1) qf_a = 1'b1;
            tick(1);
            valid = 1'b0;
            tick(1);
        end
        href = 1'b0;
        tick(3);
    endtask

    task automatic run_frame(input int rows, input int nbytes, input int full_pix, input logic ovf_a_exp);
        int fd0a, fd0b;
        fd0a = fd_cnt_a;
        fd0b = fd_cnt_b;
        push_frame(rows, nbytes, full_pix);
        vsync = 1'b1; tick(3);
        vsync = 1'b0; tick(3);
        for (int r = 0; r < rows; r++) send_row(r, nbytes, full_pix);
        vsync = 1'b1; tick(3);
        if (qf_a) begin
            tick(4);
            qf_a = 1'b0;
        end
        tick(4);
        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        check("a_overflow", {31'd0, ovf_a}, {31'd0, ovf_a_exp});
        check("b_overflow", {31'd0, ovf_b}, 0);
        check("a_frame_done_count", fd_cnt_a - fd0a, 1);
        check("b_frame_done_count", fd_cnt_b - fd0b, 1);
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic check_reset_outputs();
        check("a_reset_wr_en", {31'd0, if_a.queue_wr_en}, 0);
        check("a_reset_data", {15'd0, if_a.queue_data_out}, 0);
        check("a_reset_done_ovf", {30'd0, fd_a, ovf_a}, 0);
        check("b_reset_wr_en", {31'd0, if_b.queue_wr_en}, 0);
        check("b_reset_data", {15'd0, if_b.queue_data_out}, 0);
        check("b_reset_done_ovf", {30'd0, fd_b, ovf_b}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{rows: 2, nbytes: 6,  full_pix: -1, ovf_a: 1'b0, fixed: 1'b1};
        vecs[1] = '{rows: 1, nbytes: 12, full_pix: -1, ovf_a: 1'b0, fixed: 1'b0};
        vecs[2] = '{rows: 3, nbytes: 4,  full_pix: -1, ovf_a: 1'b0, fixed: 1'b0};
        vecs[3] = '{rows: 2, nbytes: 5,  full_pix: -1, ovf_a: 1'b0, fixed: 1'b0};
        vecs[4] = '{rows: 2, nbytes: 6,  full_pix: 1,  ovf_a: 1'b1, fixed: 1'b0};
        vecs[5] = '{rows: 1, nbytes: 6,  full_pix: -1, ovf_a: 1'b1, fixed: 1'b0};

        reset_n = 1'b0;
        vsync = 1'b0; href = 1'b0; valid = 1'b0; data = '0;
        qf_a = 1'b0; qf_b = 1'b0;
        tick(3);
        check_reset_outputs();
        reset_n = 1'b1;
        tick(2);

        for (int v = 0; v < 6; v++) begin
            fill_bytes(vecs[v].fixed);
            run_frame(vecs[v].rows, vecs[v].nbytes, vecs[v].full_pix, vecs[v].ovf_a);
        end

        // Reset in the middle of a row: only words emitted before reset may appear.
        fill_bytes(1'b0);
        exp_a.push_back(17'h10000); exp_a.push_back(17'h10001);
        exp_a.push_back(pix(0, 0)); exp_a.push_back(pix(0, 1));
        exp_b.push_back(17'h10000); exp_b.push_back(17'h10001);
        exp_b.push_back(pix(0, 0)); exp_b.push_back(pix(0, 1));
        vsync = 1'b0; tick(3);
        href = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = bts[0][i]; valid = 1'b1; tick(1);
            valid = 1'b0; tick(1);
        end
        tick(3);
        reset_n = 1'b0;
        tick(2);
        check_reset_outputs();
        check("a_pre_reset_drained", exp_a.size(), 0);
        check("b_pre_reset_drained", exp_b.size(), 0);
        href = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        send_row(1, 6, -1);
        send_row(2, 6, -1);
        check("a_no_frame_without_vsync_fall", {31'd0, if_a.queue_wr_en}, 0);
        check("b_no_frame_without_vsync_fall", {31'd0, if_b.queue_wr_en}, 0);

        fill_bytes(1'b0);
        run_frame(2, 8, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_frame_packer.md
Name: cam_frame_packer

Overview:
- Write-side producer for the 17-bit pixel queue drained by the LCD controller.
- Samples an OV7670-style byte stream (vsync, href, 8-bit data with valid strobe) already synchronised to clk.
- Packs byte pairs into RGB565 words and frames them with in-band markers:
  - 17'h10000: frame start
  - 17'h10001: row start
  - 17'h1FFFF: frame end
- Pixel words carry bit16 = 0.
- Crops to the LCD geometry. On queue overflow it drops the rest of the frame but always closes it cleanly.

Parameters:
- FRAME_WIDTH, 480: maximum pixels written per row; extra pixels are discarded.
- FRAME_HEIGHT, 272: maximum rows written per frame; extra rows are discarded and get no marker.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- cam_vsync  input  1  camera vsync, high = vertical blank.
- cam_href  input  1  camera line-valid.
- cam_data  input  8  camera byte.
- cam_data_valid  input  1  cam_data is valid this cycle (one per camera pclk).
- queue_full  input  1  queue cannot accept a write this cycle.
- queue_data_out  output  17  word to queue.
- queue_wr_en  output  1  write strobe; queue_data_out is valid when high.
- frame_done  output  1  one-cycle pulse when 17'h1FFFF is written.
- overflow  output  1  sticky; set when a write was needed while queue_full. Cleared only by reset.

Behaviour:
- Reset (reset_n low at clk edge): all outputs are 0; state = IDLE; counters, byte phase and edge-detect registers are cleared. Reset mid-frame abandons the frame with no frame-end marker.
- Edge detect: registered copies of cam_vsync and cam_href.
  - vsync_fall = prev 1, now 0.
  - vsync_rise = prev 0, now 1.
  - href_rise and href_fall defined the same way.
  - After reset, previous values are taken as 0. A frame therefore cannot start until a full vsync high→low is seen.
- Outputs: all registered, one-cycle latency from the triggering sample. queue_wr_en is high for exactly one cycle per word.
- States:
  - IDLE: wait for vsync_fall → FRAME_START.
  - FRAME_START: if !queue_full, write 17'h10000 and go to WAIT_ROW with row_cnt = 0. If queue_full, wait here; no camera data is lost because the blank is active.
  - WAIT_ROW:
    - vsync_rise → FRAME_END.
    - href_rise with row_cnt < FRAME_HEIGHT → write 17'h10001 (if queue_full: overflow = 1, go to DROP), clear col_cnt and byte phase, go to ROW_DATA.
    - href_rise with row_cnt ≥ FRAME_HEIGHT → SKIP_ROW.
  - ROW_DATA, on each cam_data_valid while cam_href = 1:
    - Phase 0: latch hi_byte.
    - Phase 1: form word = {1'b0, hi_byte, cam_data}, i.e. R = hi[7:3], G = {hi[2:0], lo[7:5]}, B = lo[4:0].
    - If col_cnt < FRAME_WIDTH: write the word (if queue_full: overflow = 1, go to DROP) and increment col_cnt. Otherwise discard silently.
    - On href_fall: increment row_cnt, discard any odd leftover byte, go to WAIT_ROW.
    - vsync_rise inside a row: treat as href_fall, then go to FRAME_END.
  - SKIP_ROW: ignore data; href_fall → WAIT_ROW; vsync_rise → FRAME_END.
  - FRAME_END: wait until !queue_full, write 17'h1FFFF, pulse frame_done, go to IDLE.
  - DROP: ignore all camera data until vsync_rise → FRAME_END. The marker is still emitted, so the consumer always sees a closed frame.
- Simultaneous events:
  - href_rise and vsync_rise in the same cycle: vsync wins → FRAME_END.
  - A valid byte in the same cycle as href_rise is taken as phase 0 of the new row.
- Counters are 11 bits; comparisons are unsigned.
- Rows narrower than FRAME_WIDTH are written short; no padding.

Test Plan:
- Reset, then a 2-row × 3-pixel frame (bytes F8,00 / 07,E0 / 00,1F per row), queue never full → written sequence: 10000, 10001, 0F800, 007E0, 0001F, 10001, 0F800, 007E0, 0001F, 1FFFF; frame_done pulses once; overflow = 0.
- FRAME_WIDTH = 4, a row of 6 pixels → exactly 4 pixel words after 10001, no overflow.
- FRAME_HEIGHT = 2, 3 rows → two 10001 markers, third row absent, 1FFFF written.
- queue_full asserted on the 2nd pixel of row 0 → overflow = 1; no further writes until vsync rises; then 1FFFF is written once queue_full drops; the next frame is normal and overflow stays 1.
- Row with 5 bytes (odd) → 2 pixel words; 5th byte discarded; next row starts at phase 0.
- reset_n low mid-row, then a clean frame → no stray words, outputs 0 during reset, and the new frame starts only after a fresh vsync falling edge.
